pwm_multichannel: RTL and testbench

PWM_MULTICHANNEL -- requirements
Module: pwm_multichannel

---
 rtl/pwm_multichannel.sv | 177 +++++++++++++++++
 tb/tb_pwm_multichannel.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_multichannel.sv
// pwm_multichannel: NUM_CH-channel PWM generator sharing one period counter.
// New duty/period/mode values are double-buffered and only take effect at a
// period boundary (or immediately while disabled), so a period is never torn.
// Optional feature: define PWM_CENTER_ALIGN_EN to add center-aligned
// (up/down) counting selected by center_mode; otherwise edge mode only.
module pwm_multichannel #(
    parameter int BIT_WIDTH = 8,
    parameter int NUM_CH    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [BIT_WIDTH-1:0]        max_value,
    input  logic [NUM_CH*BIT_WIDTH-1:0] duty,
    input  logic                        center_mode,
    input  logic                        update,
    output logic [NUM_CH-1:0]           pwm_out,
    output logic                        period_start,
    output logic                        update_pending
);

    localparam logic [BIT_WIDTH-1:0] ZERO = {BIT_WIDTH{1'b0}};
    localparam logic [BIT_WIDTH-1:0] ONE  = {{(BIT_WIDTH-1){1'b0}}, 1'b1};

    logic [BIT_WIDTH-1:0] cnt_r;
    logic [BIT_WIDTH-1:0] next_cnt_s;
    logic                 boundary_s;
    logic [BIT_WIDTH-1:0] max_act_r;
    logic [BIT_WIDTH-1:0] max_pend_r;
    logic [BIT_WIDTH-1:0] duty_act_r  [NUM_CH];
    logic [BIT_WIDTH-1:0] duty_pend_r [NUM_CH];
    logic                 pend_r;
    logic [NUM_CH-1:0]    pwm_out_r;
    logic                 period_start_r;

`ifdef PWM_CENTER_ALIGN_EN
    logic mode_act_r;
    logic mode_pend_r;
    logic dir_up_r;
    logic next_dir_up_s;
`else
    // center_mode has no effect in an edge-only build
    logic unused_center_mode_s;
    assign unused_center_mode_s = center_mode;
`endif

    // Next counter value/direction and period-boundary detection
    always_comb begin
        next_cnt_s = cnt_r;
`ifdef PWM_CENTER_ALIGN_EN
        next_dir_up_s = dir_up_r;
        if (mode_act_r) begin
            if (dir_up_r) begin
                if (cnt_r >= max_act_r) begin
                    // A peak of 0 or 1 has no distinct down leg
                    if (max_act_r <= ONE) begin
                        next_cnt_s    = ZERO;
                        next_dir_up_s = 1'b1;
                    end else begin
                        next_cnt_s    = max_act_r - ONE;
                        next_dir_up_s = 1'b0;
                    end
                end else begin
                    next_cnt_s = cnt_r + ONE;
                end
            end else begin
                if (cnt_r <= ONE) begin
                    next_cnt_s    = ZERO;
                    next_dir_up_s = 1'b1;
                end else begin
                    next_cnt_s = cnt_r - ONE;
                end
            end
        end else begin
            if (cnt_r >= max_act_r) begin
                next_cnt_s = ZERO;
            end else begin
                next_cnt_s = cnt_r + ONE;
            end
        end
`else
        if (cnt_r >= max_act_r) begin
            next_cnt_s = ZERO;
        end else begin
            next_cnt_s = cnt_r + ONE;
        end
`endif
        boundary_s = enable && (next_cnt_s == ZERO);
    end

    // Counter, active/pending register bank and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r          <= ZERO;
            max_act_r      <= ZERO;
            max_pend_r     <= ZERO;
            pend_r         <= 1'b0;
            pwm_out_r      <= {NUM_CH{1'b0}};
            period_start_r <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_act_r[i]  <= ZERO;
                duty_pend_r[i] <= ZERO;
            end
`ifdef PWM_CENTER_ALIGN_EN
            mode_act_r  <= 1'b0;
            mode_pend_r <= 1'b0;
            dir_up_r    <= 1'b1;
`endif
        end else if (!enable) begin
            pwm_out_r      <= {NUM_CH{1'b0}};
            period_start_r <= 1'b0;
            if (update) begin
                // Disabled: nothing is mid-period, so load straight into active
                max_act_r <= max_value;
                for (int i = 0; i < NUM_CH; i++) begin
                    duty_act_r[i] <= duty[i*BIT_WIDTH +: BIT_WIDTH];
                end
                pend_r <= 1'b0;
                cnt_r  <= ZERO;
`ifdef PWM_CENTER_ALIGN_EN
                mode_act_r <= center_mode;
                dir_up_r   <= 1'b1;
`endif
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_out_r[i] <= (cnt_r < duty_act_r[i]);
            end
            period_start_r <= (cnt_r == ZERO);
            if (update && boundary_s) begin
                // Fresh values at a boundary win over anything still pending
                max_act_r <= max_value;
                for (int i = 0; i < NUM_CH; i++) begin
                    duty_act_r[i] <= duty[i*BIT_WIDTH +: BIT_WIDTH];
                end
                pend_r <= 1'b0;
                cnt_r  <= ZERO;
`ifdef PWM_CENTER_ALIGN_EN
                mode_act_r <= center_mode;
                dir_up_r   <= 1'b1;
`endif
            end else if (boundary_s && pend_r) begin
                max_act_r <= max_pend_r;
                for (int i = 0; i < NUM_CH; i++) begin
                    duty_act_r[i] <= duty_pend_r[i];
                end
                pend_r <= 1'b0;
                cnt_r  <= ZERO;
`ifdef PWM_CENTER_ALIGN_EN
                mode_act_r <= mode_pend_r;
                dir_up_r   <= 1'b1;
`endif
            end else begin
                if (update) begin
                    // Mid-period request: park it; a later one overwrites it
                    max_pend_r <= max_value;
                    for (int i = 0; i < NUM_CH; i++) begin
                        duty_pend_r[i] <= duty[i*BIT_WIDTH +: BIT_WIDTH];
                    end
                    pend_r <= 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
                    mode_pend_r <= center_mode;
`endif
                end
                cnt_r <= next_cnt_s;
`ifdef PWM_CENTER_ALIGN_EN
                dir_up_r <= next_dir_up_s;
`endif
            end
        end
    end

    assign pwm_out        = pwm_out_r;
    assign period_start   = period_start_r;
    assign update_pending = pend_r;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Scoreboard bench for pwm_multichannel: the stimulus process pushes the
// expected registered outputs for each upcoming clock edge; a monitor pops
// and compares them on the falling edge once that edge has happened.
module tb_pwm_multichannel;
    localparam int BW = 8;
    localparam int NC = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic [BW-1:0]    max_value;
    logic [NC*BW-1:0] duty;
    logic             center_mode;
    logic             update;
    logic [NC-1:0]    pwm_out;
    logic             period_start;
    logic             update_pending;

    pwm_multichannel #(.BIT_WIDTH(BW), .NUM_CH(NC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .max_value      (max_value),
        .duty           (duty),
        .center_mode    (center_mode),
        .update         (update),
        .pwm_out        (pwm_out),
        .period_start   (period_start),
        .update_pending (update_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [NC-1:0] pwm;
        logic        ps;
        logic        pend;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected pwm_out for a counter value c and the four channel duties
    function automatic logic [NC-1:0] pw(input int c, input int d0, input int d1,
                                         input int d2, input int d3);
        pw = {c < d3, c < d2, c < d1, c < d0};
    endfunction

    // Queue the expected outputs of the next rising edge, then move to the falling edge
    task automatic expect_next(input string name, input logic [NC-1:0] p,
                               input logic ps, input logic pend);
        exp_t e;
        e.cyc  = cyc + 1;
        e.pwm  = p;
        e.ps   = ps;
        e.pend = pend;
        e.name = name;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare every expectation that has come due
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            checks++;
            if (e.cyc != cyc || pwm_out !== e.pwm || period_start !== e.ps ||
                update_pending !== e.pend) begin
                failures++;
                $display("FAIL %s cyc=%0d/%0d pwm_out=%b want %b period_start=%b want %b update_pending=%b want %b",
                         e.name, cyc, e.cyc, pwm_out, e.pwm, period_start, e.ps,
                         update_pending, e.pend);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int  c;
        int  d1;
        logic pend;

        rst_n       = 1'b0;
        enable      = 1'b0;
        update      = 1'b0;
        center_mode = 1'b0;
        max_value   = 8'd0;
        duty        = 32'd0;
        @(negedge clk);
        expect_next("reset0", 4'b0000, 1'b0, 1'b0);
        expect_next("reset1", 4'b0000, 1'b0, 1'b0);

        // Initial load while disabled: max=9, duty {ch3..ch0} = {12,9,3,0}
        rst_n     = 1'b1;
        update    = 1'b1;
        max_value = 8'd9;
        duty      = {8'd12, 8'd9, 8'd3, 8'd0};
        expect_next("load_disabled", 4'b0000, 1'b0, 1'b0);
        update = 1'b0;
        enable = 1'b1;

        // k = output index since enable; counter value shown is k mod 10
        for (int k = 0; k < 105; k++) begin
            c      = k % 10;
            update = 1'b0;
            if (k == 34) begin update = 1'b1; duty[BW +: BW] = 8'd7; end
            if (k == 69) begin update = 1'b1; duty[BW +: BW] = 8'd5; end
            if (k == 82) begin update = 1'b1; duty[BW +: BW] = 8'd2; end
            if (k == 85) begin update = 1'b1; duty[BW +: BW] = 8'd6; end
            d1   = (k < 40) ? 3 : (k < 70) ? 7 : (k < 90) ? 5 : 6;
            pend = ((k >= 34) && (k <= 38)) || ((k >= 82) && (k <= 88));
            expect_next($sformatf("run_k%0d", k), pw(c, 0, d1, 9, 12), c == 0, pend);
        end
        update = 1'b0;

        // Disable at count 5 for three cycles: outputs low, count held
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expect_next($sformatf("disabled_%0d", k), 4'b0000, 1'b0, 1'b0);
        end
        enable = 1'b1;
        for (int k = 105; k < 123; k++) begin
            c      = k % 10;
            update = 1'b0;
            if (k == 121) begin update = 1'b1; duty[BW +: BW] = 8'd1; end
            pend = (k >= 121);
            expect_next($sformatf("resume_k%0d", k), pw(c, 0, 6, 9, 12), c == 0, pend);
        end

        // Reset mid-period overrides enable and update
        rst_n  = 1'b0;
        update = 1'b1;
        expect_next("reset_mid", 4'b0000, 1'b0, 1'b0);
        rst_n  = 1'b1;
        update = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expect_next($sformatf("after_reset_max0_%0d", k), 4'b0000, 1'b1, 1'b0);
        end

        // Center-mode request: max=4, ch0 duty=2
        enable      = 1'b0;
        update      = 1'b1;
        max_value   = 8'd4;
        duty        = {8'd0, 8'd0, 8'd0, 8'd2};
        center_mode = 1'b1;
        expect_next("center_load", 4'b0000, 1'b0, 1'b0);
        update = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 16; k++) begin
`ifdef PWM_CENTER_ALIGN_EN
            // Counter runs 0,1,2,3,4,3,2,1
            c = k % 8;
            c = (c <= 4) ? c : 8 - c;
            expect_next($sformatf("center_k%0d", k), pw(c, 2, 0, 0, 0), (k % 8) == 0, 1'b0);
`else
            // center_mode ignored: plain 5-cycle edge period
            c = k % 5;
            expect_next($sformatf("edge_only_k%0d", k), pw(c, 2, 0, 0, 0), c == 0, 1'b0);
`endif
        end

        @(negedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain left=%0d want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
